// File: rtl/regfile_sequencer.sv
// Micro-op sequencer for a 4 x 8-bit register file: fetch operands through the single
// combinational read port, run the ALU, write the result back, report flags.
module regfile_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_enable,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag,
  output logic                  carry_flag
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpMov = 3'b101;
  localparam logic [2:0] OpLdi = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  typedef enum logic [1:0] {StIdle, StRdA, StRdB, StWb} state_e;

  state_e                  state_q;
  logic [2:0]              op_q;
  logic [ADDR_WIDTH-1:0]   rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0]   imm_q, opa_q, opb_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q, carry_q, done_q;

  logic [DATA_WIDTH:0]     sum, diff;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;

  // The extra top bit is the carry for ADD and the borrow (a < b) for SUB/CMP.
  assign sum  = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff = {1'b0, opa_q} - {1'b0, opb_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
      end
      OpSub, OpCmp: begin
        alu_res   = diff[DATA_WIDTH-1:0];
        alu_carry = diff[DATA_WIDTH];
      end
      OpAnd:   alu_res = opa_q & opb_q;
      OpOr:    alu_res = opa_q | opb_q;
      OpXor:   alu_res = opa_q ^ opb_q;
      OpMov:   alu_res = opa_q;
      OpLdi:   alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            rd_q    <= instr_rd;
            rs1_q   <= instr_rs1;
            rs2_q   <= instr_rs2;
            imm_q   <= instr_imm;
            state_q <= (instr_op == OpLdi) ? StWb : StRdA;
          end
        end
        StRdA: begin
          opa_q   <= rf_read_data;
          state_q <= (op_q == OpMov) ? StWb : StRdB;
        end
        StRdB: begin
          opb_q   <= rf_read_data;
          state_q <= StWb;
        end
        StWb: begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          carry_q  <= alu_carry;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port strobes decode from state so reset kills a pending write immediately.
  always_comb begin
    rf_read_address  = '0;
    rf_write_address = '0;
    rf_write_data    = '0;
    rf_write_enable  = 1'b0;
    case (state_q)
      StRdA: rf_read_address = rs1_q;
      StRdB: rf_read_address = rs2_q;
      StWb: begin
        rf_write_address = rd_q;
        rf_write_data    = alu_res;
        rf_write_enable  = (op_q != OpCmp);
      end
      default: ;
    endcase
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign result      = result_q;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: behavioural register file, reference model queue,
// negedge monitor for writes and completions, one task per scenario.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [1:0] instr_rd = 2'd0, instr_rs1 = 2'd0, instr_rs2 = 2'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [1:0] rf_read_address, rf_write_address;
  logic [7:0] rf_read_data, rf_write_data;
  logic       rf_write_enable, busy, done, zero_flag, carry_flag;
  logic [7:0] result;

  regfile_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk              (clk),
    .reset_b          (reset_b),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_op         (instr_op),
    .instr_rd         (instr_rd),
    .instr_rs1        (instr_rs1),
    .instr_rs2        (instr_rs2),
    .instr_imm        (instr_imm),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .zero_flag        (zero_flag),
    .carry_flag       (carry_flag)
  );

  always #5 clk = ~clk;

  logic [7:0] rf [4];
  assign rf_read_data = rf[rf_read_address];
  always @(posedge clk) if (rf_write_enable) rf[rf_write_address] <= rf_write_data;

  typedef struct packed {logic [7:0] res; logic z; logic c;} exp_t;
  typedef struct packed {logic [1:0] a; logic [7:0] d;} wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] mreg [4];
  int vectors = 0, miscompares = 0, we_cnt = 0;

  function automatic logic [8:0] model_alu(input int op, input int a, input int b, input int imm);
    int s;
    case (op)
      0: begin s = a + b; return {(s > 255) ? 1'b1 : 1'b0, 8'(s)}; end
      1, 7: begin s = a - b + 256; return {(a < b) ? 1'b1 : 1'b0, 8'(s)}; end
      2: return {1'b0, 8'(a & b)};
      3: return {1'b0, 8'(a | b)};
      4: return {1'b0, 8'(a ^ b)};
      5: return {1'b0, 8'(a)};
      default: return {1'b0, 8'(imm)};
    endcase
  endfunction

  task automatic push_model(input int op, input int rd, input int rs1, input int rs2,
                            input int imm);
    logic [8:0] r;
    exp_t e;
    wr_t w;
    r = model_alu(op, int'(mreg[rs1]), int'(mreg[rs2]), imm);
    e.res = r[7:0]; e.z = (r[7:0] == 8'd0); e.c = r[8];
    exp_q.push_back(e);
    if (op != 7) begin
      w.a = 2'(rd); w.d = r[7:0];
      wr_q.push_back(w);
      mreg[rd] = r[7:0];
    end
  endtask

  // Monitor: every write and every done pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_b) begin
      if (rf_write_enable) begin
        wr_t w;
        we_cnt++;
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%h, none expected",
                   rf_write_address, rf_write_data);
        end else begin
          w = wr_q.pop_front();
          if (rf_write_address !== w.a || rf_write_data !== w.d) begin
            miscompares++;
            $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                     rf_write_address, rf_write_data, w.a, w.d);
          end
        end
      end
      if (done) begin
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: result=%h, none expected", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res || zero_flag !== e.z || carry_flag !== e.c) begin
            miscompares++;
            $display("FAIL completion: got res=%h z=%b c=%b, want res=%h z=%b c=%b",
                     result, zero_flag, carry_flag, e.res, e.z, e.c);
          end
        end
      end
    end
  end

  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
    instr_op = 3'(op); instr_rd = 2'(rd); instr_rs1 = 2'(rs1); instr_rs2 = 2'(rs2);
    instr_imm = 8'(imm);
  endtask

  task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input int lat, input string name);
    int n, we0;
    bit found;
    push_model(op, rd, rs1, rs2, imm);
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm);
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_accept: ready=%b, want 1", name, instr_ready);
    end
    we0 = we_cnt;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0; found = 0;
    while (!found && n < 10) begin @(negedge clk); n++; found = done; end
    vectors++;
    if (!found || n != lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles (done seen=%0d), want %0d", name, n, found, lat);
    end
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_with_done: ready=%b, want 1", name, instr_ready);
    end
    vectors++;
    if (we_cnt - we0 != ((op == 7) ? 0 : 1)) begin
      miscompares++;
      $display("FAIL %s_we_cycles: got %0d, want %0d", name, we_cnt - we0, (op == 7) ? 0 : 1);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 8'd0 ||
        zero_flag !== 1'b0 || carry_flag !== 1'b0 || rf_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b res=%h z=%b c=%b we=%b, want 1 0 0 00 0 0 0",
               instr_ready, busy, done, result, zero_flag, carry_flag, rf_write_enable);
    end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_ldi;
    run_instr(6, 1, 0, 0, 8'h3C, 2, "ldi_r1");
    run_instr(6, 2, 0, 0, 8'hC4, 2, "ldi_r2");
    vectors++;
    if (rf[1] !== 8'h3C || rf[2] !== 8'hC4) begin
      miscompares++;
      $display("FAIL ldi_regs: got r1=%h r2=%h, want 3c c4", rf[1], rf[2]);
    end
  endtask

  task automatic test_add;
    run_instr(0, 3, 1, 2, 0, 4, "add");
    vectors++;
    if (rf[3] !== 8'h00 || result !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL add_check: got r3=%h res=%h z=%b c=%b, want 00 00 1 1",
               rf[3], result, zero_flag, carry_flag);
    end
  endtask

  task automatic test_sub_xor;
    run_instr(1, 0, 1, 2, 0, 4, "sub");
    vectors++;
    if (rf[0] !== 8'h78 || result !== 8'h78 || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_check: got r0=%h res=%h z=%b c=%b, want 78 78 0 1",
               rf[0], result, zero_flag, carry_flag);
    end
    run_instr(4, 1, 1, 1, 0, 4, "xor");
    vectors++;
    if (rf[1] !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL xor_check: got r1=%h z=%b c=%b, want 00 1 0", rf[1], zero_flag, carry_flag);
    end
  endtask

  task automatic test_cmp;
    logic [7:0] snap [4];
    for (int i = 0; i < 4; i++) snap[i] = rf[i];
    run_instr(7, 2, 2, 2, 0, 4, "cmp");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rf[i] !== snap[i]) begin
        miscompares++;
        $display("FAIL cmp_reg%0d: got %h, want %h", i, rf[i], snap[i]);
      end
    end
    vectors++;
    if (result !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL cmp_flags: got res=%h z=%b c=%b, want 00 1 0", result, zero_flag, carry_flag);
    end
  endtask

  // OR is followed by MOV presented in the done cycle; junk fields are held while busy.
  task automatic test_back_to_back;
    int n;
    push_model(3, 1, 0, 2, 0);
    @(negedge clk);
    drive(3, 1, 0, 2, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!instr_ready) drive(6, $urandom_range(0, 3), 0, 0, $urandom_range(0, 255));
    end while (!instr_ready && n < 10);
    vectors++;
    if (n != 4 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_or_done: got %0d cycles done=%b, want 4 cycles done=1", n, done);
    end
    push_model(5, 3, 0, 0, 0);
    drive(5, 3, 0, 0, 0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 10);
    vectors++;
    if (n != 3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_mov_latency: got %0d cycles done=%b, want 3 cycles done=1", n, done);
    end
    vectors++;
    if (rf[3] !== 8'h78 || rf[1] !== 8'hFC) begin
      miscompares++;
      $display("FAIL b2b_regs: got r3=%h r1=%h, want 78 fc", rf[3], rf[1]);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] r2_before;
    r2_before = rf[2];
    @(negedge clk);
    drive(0, 2, 0, 0, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || rf_read_address !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_in_rdb: busy=%b raddr=%0d, want 1 0", busy, rf_read_address);
    end
    reset_b = 1'b0;
    #1;
    vectors++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 8'd0 ||
        zero_flag !== 1'b0 || carry_flag !== 1'b0 || rf_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: rdy=%b busy=%b done=%b res=%h z=%b c=%b we=%b, want 1 0 0 00 0 0 0",
               instr_ready, busy, done, result, zero_flag, carry_flag, rf_write_enable);
    end
    @(negedge clk);
    reset_b = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (rf[2] !== r2_before || rf[2] !== 8'hC4) begin
      miscompares++;
      $display("FAIL abort_r2: got %h, want %h", rf[2], r2_before);
    end
    vectors++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", exp_q.size(), wr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin rf[i] = 8'd0; mreg[i] = 8'd0; end
    test_reset();
    test_ldi();
    test_add();
    test_sub_xor();
    test_cmp();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out, want completion");
    $fatal(1, "timeout");
  end

endmodule
